// File: rtl/lcd_display_pkg.sv
// Shared types, LCD command constants and the fixed byte ROM for the
// HD44780 start-up/message sequencer.
package lcd_display_pkg;

    // Byte-writer phases; ST_DONE names the parked condition of the sequencer.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } lcd_state_e;

    // Top-level sequencer progress.
    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_e;

    localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38; // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C; // display on, cursor off
    localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06; // increment, no shift
    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01; // clear display

    localparam int unsigned NUM_BYTES = 15;
    localparam int unsigned IDX_W     = 4;

    // Byte list as {rs, byte}; indices past the list return a harmless command 0x00.
    function automatic logic [8:0] lcd_rom(input logic [IDX_W-1:0] idx);
        logic [8:0] val;
        case (idx)
            4'd0:    val = {1'b0, LCD_CMD_FUNCSET};
            4'd1:    val = {1'b0, LCD_CMD_DISPON};
            4'd2:    val = {1'b0, LCD_CMD_ENTRY};
            4'd3:    val = {1'b0, LCD_CMD_CLEAR};
            4'd4:    val = {1'b1, 8'h48}; // H
            4'd5:    val = {1'b1, 8'h45}; // E
            4'd6:    val = {1'b1, 8'h4C}; // L
            4'd7:    val = {1'b1, 8'h4C}; // L
            4'd8:    val = {1'b1, 8'h4F}; // O
            4'd9:    val = {1'b1, 8'h20}; // space
            4'd10:   val = {1'b1, 8'h57}; // W
            4'd11:   val = {1'b1, 8'h4F}; // O
            4'd12:   val = {1'b1, 8'h52}; // R
            4'd13:   val = {1'b1, 8'h4C}; // L
            4'd14:   val = {1'b1, 8'h44}; // D
            default: val = 9'h000;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/lcd_display_if.sv
// LCD-facing bus bundle: parallel data, E strobe, RS and the completion flag.
interface lcd_display_if;
    logic [7:0] lcd_data;
    logic       lcd_enable;
    logic       lcd_rs;
    logic       done;

    modport master (output lcd_data, output lcd_enable, output lcd_rs, output done);
    modport slave  (input  lcd_data, input  lcd_enable, input  lcd_rs, input  done);
endinterface

// File: rtl/lcd_byte_writer.sv
// Presents one {rs, byte} to the LCD: one setup cycle, EN_CYCLES of E high,
// HOLD_CYCLES of E low with data held. A start seen in the final hold cycle
// chains straight into the next byte's setup with no gap.
module lcd_byte_writer
    import lcd_display_pkg::*;
#(
    parameter int unsigned EN_CYCLES   = 2,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic       rs_i,
    input  logic [7:0] byte_i,
    output logic [7:0] lcd_data_o,
    output logic       lcd_rs_o,
    output logic       lcd_enable_o,
    output logic       byte_done_o
);

    localparam logic [15:0] EN_LAST   = 16'(EN_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    lcd_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic        en_q, en_d;

    // Phase sequencing; data/rs are only loaded when entering SETUP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        rs_d        = rs_q;
        byte_done_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_SETUP;
                    data_d  = byte_i;
                    rs_d    = rs_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d = ST_PULSE;
                cnt_d   = 16'd0;
            end
            ST_PULSE: begin
                if (cnt_q == EN_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    byte_done_o = 1'b1;
                    cnt_d       = 16'd0;
                    if (start_i) begin
                        state_d = ST_SETUP;
                        data_d  = byte_i;
                        rs_d    = rs_i;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 16'd0;
            end
        endcase
        en_d = (state_d == ST_PULSE);
    end

    // State, counter and registered LCD outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
        end
    end

    assign lcd_data_o   = data_q;
    assign lcd_rs_o     = rs_q;
    assign lcd_enable_o = en_q;

endmodule

// File: rtl/lcd_display.sv
// HD44780 sequencer: sends four init commands then "HELLO WORLD" and parks
// with done set. Owns the byte index and completion state; strobe timing
// lives in lcd_byte_writer.
module lcd_display
    import lcd_display_pkg::*;
#(
    parameter int unsigned EN_CYCLES   = 2,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset,
    lcd_display_if.master lcd
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic             start_s;
    logic [IDX_W-1:0] sel_idx_s;
    logic [8:0]       rom_s;
    logic             byte_done_s;
    logic [7:0]       wr_data_s;
    logic             wr_rs_s;
    logic             wr_en_s;

    // Index advance: the writer is always fed the byte it will load next.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        done_d    = done_q;
        start_s   = 1'b0;
        sel_idx_s = idx_q + 4'd1;
        case (state_q)
            SEQ_IDLE: begin
                start_s   = 1'b1;
                sel_idx_s = 4'd0;
                idx_d     = 4'd0;
                state_d   = SEQ_RUN;
            end
            SEQ_RUN: begin
                if (byte_done_s) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = SEQ_DONE;
                        done_d  = 1'b1;
                    end else begin
                        start_s = 1'b1;
                        idx_d   = idx_q + 4'd1;
                    end
                end else begin
                    state_d = SEQ_RUN;
                end
            end
            SEQ_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = SEQ_IDLE;
                idx_d   = 4'd0;
                done_d  = 1'b0;
            end
        endcase
        rom_s = lcd_rom(sel_idx_s);
    end

    // Sequencer state, index and sticky done flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SEQ_IDLE;
            idx_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    lcd_byte_writer #(
        .EN_CYCLES   (EN_CYCLES),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_writer (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_s),
        .rs_i         (rom_s[8]),
        .byte_i       (rom_s[7:0]),
        .lcd_data_o   (wr_data_s),
        .lcd_rs_o     (wr_rs_s),
        .lcd_enable_o (wr_en_s),
        .byte_done_o  (byte_done_s)
    );

    assign lcd.lcd_data   = wr_data_s;
    assign lcd.lcd_rs     = wr_rs_s;
    assign lcd.lcd_enable = wr_en_s;
    assign lcd.done       = done_q;

endmodule

// File: tb/tb_lcd_display.sv
// Directed bench for lcd_display: default and stretched timing instances,
// per-edge expected outputs from the byte-period formula, captured bytes at
// each E fall, completion and mid-pulse reset behaviour.
module tb_lcd_display;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a;
    logic reset_b;

    lcd_display_if if_a ();
    lcd_display_if if_b ();

    lcd_display #(.EN_CYCLES(2), .HOLD_CYCLES(1)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .lcd   (if_a)
    );

    lcd_display #(.EN_CYCLES(5), .HOLD_CYCLES(3)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .lcd   (if_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ref_bytes [15] = '{8'h38, 8'h0C, 8'h06, 8'h01,
                                   8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20,
                                   8'h57, 8'h4F, 8'h52, 8'h4C, 8'h44};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {done, rs, enable, data}
    function automatic logic [10:0] obs_vec(input bit use_b);
        if (use_b) return {if_b.done, if_b.lcd_rs, if_b.lcd_enable, if_b.lcd_data};
        else       return {if_a.done, if_a.lcd_rs, if_a.lcd_enable, if_a.lcd_data};
    endfunction

    // Expected outputs just after edge e (edge 0 = first edge with reset high).
    function automatic logic [10:0] expect_at(input int e, input int en_c, input int hold_c);
        int p;
        int k;
        int ph;
        logic rs;
        logic en;
        p  = 1 + en_c + hold_c;
        k  = e / p;
        ph = e % p;
        if (e >= 15 * p) return {1'b1, 1'b1, 1'b0, 8'h44};
        rs = (k >= 4);
        en = (ph >= 1) && (ph <= en_c);
        return {1'b0, rs, en, ref_bytes[k]};
    endfunction

    // Runs n_edges edges after release, checking every edge and the E-fall captures.
    task automatic run_seq(input string name, input int en_c, input int hold_c,
                           input int n_edges, input bit use_b);
        logic [10:0] v;
        logic [10:0] prev;
        logic [8:0]  cap [$];
        int          pulses;
        int          unstable;
        string       msg;
        logic [7:0]  exp_b;
        pulses   = 0;
        unstable = 0;
        prev     = 11'd0;
        msg      = "HELLO WORLD";
        for (int e = 0; e < n_edges; e++) begin
            @(posedge clk);
            @(negedge clk);
            v = obs_vec(use_b);
            check_eq($sformatf("%s_edge%0d", name, e), 32'(v), 32'(expect_at(e, en_c, hold_c)));
            if (prev[8] && v[8] && (prev[7:0] != v[7:0] || prev[9] != v[9])) unstable++;
            if (prev[8] && !v[8]) begin
                pulses++;
                cap.push_back({v[9], v[7:0]});
            end
            prev = v;
        end
        check_eq({name, "_pulses"}, 32'(pulses), 32'd15);
        check_eq({name, "_stable"}, 32'(unstable), 32'd0);
        for (int i = 0; i < 15; i++) begin
            if (i < cap.size()) begin
                if (i < 4) exp_b = ref_bytes[i];
                else       exp_b = msg[i - 4];
                check_eq($sformatf("%s_cap%0d", name, i), 32'(cap[i]), 32'({(i >= 4), exp_b}));
            end
        end
    endtask

    initial begin
        reset_a = 1'b0;
        reset_b = 1'b0;

        // Reset held for three cycles on both instances.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("rst_a%0d", i), 32'(obs_vec(1'b0)), 32'd0);
            check_eq($sformatf("rst_b%0d", i), 32'(obs_vec(1'b1)), 32'd0);
        end

        // Default timing: full sequence plus 100 parked cycles after edge 60.
        reset_a = 1'b1;
        run_seq("dflt", 2, 1, 161, 1'b0);

        // Restart, then reset mid-pulse on the 'W' byte (index 10, E high after edge 41).
        reset_a = 1'b0;
        @(negedge clk);
        check_eq("rst_again", 32'(obs_vec(1'b0)), 32'd0);
        reset_a = 1'b1;
        for (int e = 0; e <= 41; e++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_eq("w_pulse", 32'(obs_vec(1'b0)), 32'({1'b0, 1'b1, 1'b1, 8'h57}));
        reset_a = 1'b0;
        #1;
        check_eq("midrst_async", 32'(obs_vec(1'b0)), 32'd0);
        @(negedge clk);
        check_eq("midrst_held", 32'(obs_vec(1'b0)), 32'd0);
        reset_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("restart_setup", 32'(obs_vec(1'b0)), 32'({1'b0, 1'b0, 1'b0, 8'h38}));
        @(posedge clk);
        @(negedge clk);
        check_eq("restart_pulse", 32'(obs_vec(1'b0)), 32'({1'b0, 1'b0, 1'b1, 8'h38}));

        // Stretched timing: E high 5 cycles, period 9, done after edge 135.
        reset_b = 1'b1;
        run_seq("slow", 5, 3, 150, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
